// File: rtl/decodificador_teclas_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: prefix FSM states,
// the special scan-code bytes and the width of one decoded event.
package decodificador_teclas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } estado_e;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_AA     = 8'hAA;
  localparam logic [7:0] SC_FA     = 8'hFA;
  localparam logic [7:0] SC_FE     = 8'hFE;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // One event is {ext, break, code}
  localparam int ENTRY_W = 10;

  // Keyboard housekeeping bytes that carry no key information when no prefix is pending
  function automatic logic es_descartable(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) || (b == SC_E1);
  endfunction

endpackage

// File: rtl/fifo_teclas.sv
// Small first-word-fall-through FIFO for decoded key events. The head entry
// is kept in a register so it is visible the cycle after it is written, and
// it keeps the last popped value while the FIFO is empty.
module fifo_teclas #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, count_after_pop;
  logic [WIDTH-1:0]      head_q, head_d;
  logic                  overflow_q, overflow_d;
  logic                  do_pop, do_write, drop;

  // Work out pop/write/drop for this edge and the resulting head entry
  always_comb begin
    do_pop          = rd_i && (count_q != '0);
    do_write        = wr_i && ((count_q != DEPTH_CNT) || do_pop);
    drop            = wr_i && (count_q == DEPTH_CNT) && !do_pop;
    count_after_pop = count_q - CW'(do_pop);
    count_d         = count_after_pop + CW'(do_write);
    rd_ptr_d        = rd_ptr_q + DEPTH_LOG2'(do_pop);
    wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(do_write);
    overflow_d      = overflow_q | drop;
    head_d          = head_q;
    if (count_after_pop == '0) begin
      if (do_write) head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, occupancy, registered head and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  assign rdata_o    = head_q;
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DEPTH_CNT);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/decodificador_teclas.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext, break, code}
// events, queues them in fifo_teclas and tracks the shift keys.
module decodificador_teclas
  import decodificador_teclas_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_in,
  input  logic       rd,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       shift
);

  estado_e              state_q;
  logic                 emit, emit_ext, emit_brk;
  logic                 lshift_q, rshift_q;
  logic [ENTRY_W-1:0]   head;
  logic                 es_prefijo;

  // Decide whether the incoming byte completes an event and which flags it carries
  always_comb begin
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    es_prefijo = (scan_in == SC_E0) || (scan_in == SC_F0);
    if (rx_done_tick && !es_prefijo) begin
      unique case (state_q)
        ST_IDLE:    emit = !es_descartable(scan_in);
        ST_EXT:     begin emit = 1'b1; emit_ext = 1'b1; end
        ST_BRK:     begin emit = 1'b1; emit_brk = 1'b1; end
        ST_EXT_BRK: begin emit = 1'b1; emit_ext = 1'b1; emit_brk = 1'b1; end
        default:    emit = 1'b0;
      endcase
    end
  end

  // Prefix FSM: remembers pending E0 / F0 until a key byte arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else if (rx_done_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_in == SC_E0)      state_q <= ST_EXT;
          else if (scan_in == SC_F0) state_q <= ST_BRK;
          else                       state_q <= ST_IDLE;
        end
        ST_EXT: begin
          if (scan_in == SC_F0)      state_q <= ST_EXT_BRK;
          else if (scan_in == SC_E0) state_q <= ST_EXT;
          else                       state_q <= ST_IDLE;
        end
        ST_BRK: begin
          if (scan_in == SC_E0)      state_q <= ST_EXT_BRK;
          else if (scan_in == SC_F0) state_q <= ST_BRK;
          else                       state_q <= ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (es_prefijo) state_q <= ST_EXT_BRK;
          else            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Shift tracking follows every plain make/break, even if the FIFO drops the event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
    end else if (emit && !emit_ext) begin
      if (scan_in == SC_LSHIFT) lshift_q <= !emit_brk;
      if (scan_in == SC_RSHIFT) rshift_q <= !emit_brk;
    end
  end

  assign shift = lshift_q | rshift_q;

  fifo_teclas #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_i       (emit),
    .wdata_i    ({emit_ext, emit_brk, scan_in}),
    .rd_i       (rd),
    .rdata_o    (head),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow)
  );

  assign key_ext   = head[9];
  assign key_break = head[8];
  assign key_code  = head[7:0];

endmodule

// File: tb/tb_decodificador_teclas.sv
// Self-checking bench for decodificador_teclas: directed scan-code sequences
// followed by random traffic, all compared against a queue-based event model.
module tb_decodificador_teclas;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxDoneTick;
  logic [7:0] scanIn;
  logic       rd;
  logic [7:0] keyCode;
  logic       keyExt, keyBreak, empty, full, overflow, shift;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: pending prefix flags, event queue, sticky flags, held shifts
  bit [9:0] modelQ[$];
  bit [9:0] modelLast;
  bit       modelExt, modelBrk, modelOverflow, modelLShift, modelRShift;

  always #5 clk = ~clk;

  decodificador_teclas #(.DEPTH_LOG2(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rxDoneTick),
    .scan_in      (scanIn),
    .rd           (rd),
    .key_code     (keyCode),
    .key_ext      (keyExt),
    .key_break    (keyBreak),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .shift        (shift)
  );

  // Clear the model to its post-reset contents
  function automatic void modelReset();
    modelQ.delete();
    modelLast     = '0;
    modelExt      = 1'b0;
    modelBrk      = 1'b0;
    modelOverflow = 1'b0;
    modelLShift   = 1'b0;
    modelRShift   = 1'b0;
  endfunction

  // Advance the model by one clock edge with the given inputs
  function automatic void modelStep(input bit tick, input bit [7:0] b, input bit r);
    bit       wasFull = (modelQ.size() == 4);
    bit       popNow  = r && (modelQ.size() > 0);
    bit [9:0] entry;
    if (popNow) modelLast = modelQ.pop_front();
    if (!tick) return;
    if (b == 8'hE0) begin
      modelExt = 1'b1;
    end else if (b == 8'hF0) begin
      modelBrk = 1'b1;
    end else if (!modelExt && !modelBrk &&
                 (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hE1)) begin
      // housekeeping byte, nothing to report
    end else begin
      entry = {modelExt, modelBrk, b};
      if (!modelExt) begin
        if (b == 8'h12) modelLShift = !modelBrk;
        if (b == 8'h59) modelRShift = !modelBrk;
      end
      if (wasFull && !popNow) modelOverflow = 1'b1;
      else                    modelQ.push_back(entry);
      modelExt = 1'b0;
      modelBrk = 1'b0;
    end
  endfunction

  task automatic checkValue(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output with what the model predicts right now
  task automatic checkOutput(input string tag);
    bit [9:0] head = (modelQ.size() > 0) ? modelQ[0] : modelLast;
    checkValue({tag, "/key_code"},  {2'b00, keyCode},   {2'b00, head[7:0]});
    checkValue({tag, "/key_ext"},   {9'd0, keyExt},     {9'd0, head[9]});
    checkValue({tag, "/key_break"}, {9'd0, keyBreak},   {9'd0, head[8]});
    checkValue({tag, "/empty"},     {9'd0, empty},      {9'd0, modelQ.size() == 0});
    checkValue({tag, "/full"},      {9'd0, full},       {9'd0, modelQ.size() == 4});
    checkValue({tag, "/overflow"},  {9'd0, overflow},   {9'd0, modelOverflow});
    checkValue({tag, "/shift"},     {9'd0, shift},      {9'd0, modelLShift | modelRShift});
  endtask

  // Drive one clock cycle of inputs, update the model and check after the edge
  task automatic applyStimulus(input bit tick, input bit [7:0] b, input bit r, input string tag);
    rxDoneTick = tick;
    scanIn     = b;
    rd         = r;
    @(posedge clk);
    modelStep(tick, b, r);
    #1;
    rxDoneTick = 1'b0;
    rd         = 1'b0;
    checkOutput(tag);
  endtask

  // Assert reset mid-cycle, check its immediate effect, release on a falling edge
  task automatic resetPulse(input string tag);
    reset = 1'b0;
    #2;
    modelReset();
    checkOutput({tag, "/during"});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "/after"});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, tag);
  endtask

  logic [7:0] pool [10];
  int         pick;
  logic [7:0] rndByte;

  initial begin
    reset      = 1'b0;
    rxDoneTick = 1'b0;
    scanIn     = 8'h00;
    rd         = 1'b0;
    pool = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hFE, 8'hE1, 8'h12, 8'h59, 8'h1C, 8'h75};

    resetPulse("reset0");

    // make then break of the same key
    applyStimulus(1'b1, 8'h1C, 1'b0, "mkbrk1");
    applyStimulus(1'b1, 8'hF0, 1'b0, "mkbrk2");
    applyStimulus(1'b1, 8'h1C, 1'b0, "mkbrk3");
    drain("mkbrkDrain");

    // extended make and extended break, then a plain byte to confirm IDLE
    applyStimulus(1'b1, 8'hE0, 1'b0, "ext1");
    applyStimulus(1'b1, 8'h75, 1'b0, "ext2");
    applyStimulus(1'b1, 8'hE0, 1'b0, "ext3");
    applyStimulus(1'b1, 8'hF0, 1'b0, "ext4");
    applyStimulus(1'b1, 8'h75, 1'b0, "ext5");
    applyStimulus(1'b1, 8'h75, 1'b0, "ext6");
    drain("extDrain");

    // left shift held around another key
    applyStimulus(1'b1, 8'h12, 1'b0, "shift1");
    applyStimulus(1'b1, 8'h1C, 1'b0, "shift2");
    applyStimulus(1'b1, 8'hF0, 1'b0, "shift3");
    applyStimulus(1'b1, 8'h12, 1'b0, "shift4");
    drain("shiftDrain");

    // fill past capacity, then empty
    resetPulse("resetFill");
    applyStimulus(1'b1, 8'h15, 1'b0, "fill1");
    applyStimulus(1'b1, 8'h1D, 1'b0, "fill2");
    applyStimulus(1'b1, 8'h24, 1'b0, "fill3");
    applyStimulus(1'b1, 8'h2D, 1'b0, "fill4");
    applyStimulus(1'b1, 8'h2C, 1'b0, "fill5");
    drain("fillDrain");

    // simultaneous write and pop while full
    resetPulse("resetSim");
    applyStimulus(1'b1, 8'h15, 1'b0, "sim1");
    applyStimulus(1'b1, 8'h1D, 1'b0, "sim2");
    applyStimulus(1'b1, 8'h24, 1'b0, "sim3");
    applyStimulus(1'b1, 8'h2D, 1'b0, "sim4");
    applyStimulus(1'b1, 8'h35, 1'b1, "sim5");
    drain("simDrain");

    // housekeeping bytes, pending prefix killed by reset
    applyStimulus(1'b1, 8'hAA, 1'b0, "hk1");
    applyStimulus(1'b1, 8'hFA, 1'b0, "hk2");
    applyStimulus(1'b1, 8'hE0, 1'b0, "hk3");
    resetPulse("resetMid");
    applyStimulus(1'b1, 8'h1C, 1'b0, "hk4");
    drain("hkDrain");

    // random traffic mixing prefixes, housekeeping bytes and pops
    for (int i = 0; i < 400; i++) begin
      pick    = $urandom_range(0, 12);
      rndByte = (pick < 10) ? pool[pick] : 8'($urandom);
      applyStimulus($urandom_range(0, 2) != 0, rndByte, $urandom_range(0, 3) == 0, "random");
      if (i == 200) resetPulse("resetRandom");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
